mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the MIPS datapath, generalising the single-cycle ALU with a
//  multi-cycle mode. Supports MULT/MULTU/DIV/DIVU and owns the HI/LO registers.
//  The unit sits beside the main ALU: the controller pulses start with operands rs/rt,
//  stalls the PC while busy, then reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand width; product/quotient+remainder split across hi/lo (each WIDTH bits)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous, active-low reset
//  start        in   1        launch operation (sampled only in IDLE)
//  op           in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a            in   WIDTH    rs: multiplicand / dividend
//  b            in   WIDTH    rt: multiplier / divisor
//  hi_we        in   1        MTHI write strobe
//  lo_we        in   1        MTLO write strobe
//  wdata        in   WIDTH    MTHI/MTLO data
//  busy         out  1        operation in progress; PC must stall
//  done         out  1        one-cycle pulse: hi/lo updated this cycle
//  div_by_zero  out  1        valid with done; 1 if DIV/DIVU had b==0
//  hi           out  WIDTH    HI register (product upper half / remainder)
//  lo           out  WIDTH    LO register (product lower half / quotient)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
//    Reset mid-operation aborts the operation; no partial result reaches hi/lo.
//  - FSM: IDLE -> RUN -> FIX -> IDLE.
//    IDLE: start=1 at edge k latches op, |a|, |b| (magnitudes for signed ops), the sign flags,
//      iteration counter=WIDTH, and enters RUN; busy=1 from edge k.
//    RUN: one radix-2 step per edge (shift-add for mul, restoring subtract for div);
//      WIDTH steps on edges k+1..k+WIDTH, then go to FIX.
//    FIX (edge k+WIDTH+1): apply sign correction, write hi/lo, done=1, busy=0, go to IDLE.
//    Total latency: done is high in the cycle after edge k+WIDTH+1 (WIDTH+2 cycles from start).
//  - done and div_by_zero are single-cycle and self-clear at the next edge.
//  - Multiply: full 2*WIDTH-bit product; signed product is the two's complement of the
//    magnitude product when sign(a)^sign(b); hi=upper WIDTH bits, lo=lower WIDTH bits.
//  - Divide: quotient sign = sign(a)^sign(b); remainder sign = sign(a); lo=quotient, hi=remainder.
//    DIV with a=most-negative and b=-1: lo=most-negative (wraps), hi=0; no flag.
//  - Divide by zero: full latency still applies; on done, hi=a (original), lo=all ones,
//    div_by_zero=1.
//  - start while busy: ignored; no queueing.
//  - MTHI/MTLO: hi_we/lo_we in IDLE write wdata at the edge, with no done pulse.
//    They are ignored while busy or in the same cycle as an accepted start (start wins).
//    hi_we and lo_we may assert together.
//  - hi/lo hold their value between operations; the operand ports are don't-care after the
//    start edge.
// TESTING (WIDTH=32)
//  1. MULTU a=FFFFFFFF b=FFFFFFFF -> done in cycle 34 after start; hi=FFFFFFFE lo=00000001;
//     busy high 33 cycles.
//  2. MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=2 ->
//     lo=FFFFFFFD hi=FFFFFFFF.
//  3. DIVU a=00000064 b=0 -> hi=00000064 lo=FFFFFFFF div_by_zero=1 for one cycle with done.
//  4. DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000 div_by_zero=0.
//  5. Start MULTU 7*6, re-pulse start (DIVU 9/3) at cycle 5 -> second start ignored;
//     hi=0 lo=2A, single done.
//  6. Start DIVU, drop rst_n at cycle 10 -> busy=0 done=0 hi=lo=0 next cycle;
//     then MTLO wdata=1234 -> lo=1234 with no done pulse.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO registers.
// One radix-2 step per clock: shift-add multiply, restoring divide, then a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted only when busy==0 (IDLE); busy rises at the accepting
    // edge and falls at the edge that writes hi/lo, where done pulses for exactly one cycle.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [1:0]         op_r;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               zero_div;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Multiply: acc = {partial, multiplier}; the addend is |a|.
    // Divide:   acc = {remainder, dividend/quotient}; the addend is |b|.
    always_comb begin
        mag_a_in  = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b_in  = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? addend : '0)};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, addend};
        if (op_r[1]) begin
            if (div_diff[WIDTH])
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Signed results are computed on magnitudes and corrected here; the remainder follows a's sign.
    always_comb begin
        zero_div = op_r[1] && (addend == '0);
        prod_fix = (op_r[0] && (sign_a ^ sign_b)) ? -acc : acc;
        quo_fix  = (op_r[0] && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = (op_r[0] && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!op_r[1]) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (zero_div) begin
            hi_fix = a_orig;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_r        <= 2'b00;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_orig      <= '0;
            addend      <= '0;
            acc         <= '0;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sign_a <= op[0] & a[WIDTH-1];
                        sign_b <= op[0] & b[WIDTH-1];
                        a_orig <= a;
                        addend <= op[1] ? mag_b_in : mag_a_in;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a_in : mag_b_in)};
                        count  <= CW'(WIDTH);
                        state  <= S_RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi          <= hi_fix;
                    lo          <= lo_fix;
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32): directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: full-width arithmetic straight from the instruction definitions
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                      output logic [31:0] rhi, output logic [31:0] rlo,
                                      output logic rdbz);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = $signed(xa);
        sb = $signed(xb);
        rdbz = 1'b0;
        if (o == 2'b00) begin
            p = {32'b0, xa} * {32'b0, xb};
            rhi = p[63:32]; rlo = p[31:0];
        end else if (o == 2'b01) begin
            p = sa * sb;
            rhi = p[63:32]; rlo = p[31:0];
        end else if (xb == 32'd0) begin
            rhi = xa; rlo = 32'hFFFF_FFFF; rdbz = 1'b1;
        end else if (o == 2'b10) begin
            rlo = xa / xb; rhi = xa % xb;
        end else begin
            q = sa / sb; r = sa % sb;
            p = q; rlo = p[31:0];
            p = r; rhi = p[31:0];
        end
    endfunction

    // driver: pulse start, then wait (bounded) for done; lat=0 means done never came
    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          output int lat, output int bcnt,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz,
                          output logic done_after, output logic dbz_after);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        lat = 0; bcnt = 0; rhi = '0; rlo = '0; rdbz = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c; rhi = hi; rlo = lo; rdbz = div_by_zero;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = done;
        dbz_after  = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 2'b11; a = 32'h1234; b = 32'h5;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
        logic [31:0] t_a   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000064, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] t_b   [6] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] t_hi  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000064, 32'h00000000, 32'hFFFFFFF9};
        logic [31:0] t_lo  [6] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic        t_dbz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, bcnt;
        logic [31:0] rhi, rlo;
        logic rdbz, dn_after, dbz_after;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, bcnt, rhi, rlo, rdbz, dn_after, dbz_after);
            checks++; if (lat != 34) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (bcnt != 33) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bcnt); end
            checks++; if (rhi !== t_hi[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, rhi, t_hi[i]); end
            checks++; if (rlo !== t_lo[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, rlo, t_lo[i]); end
            checks++; if (rdbz !== t_dbz[i]) begin failures++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, rdbz, t_dbz[i]); end
            checks++; if (dn_after !== 1'b0 || dbz_after !== 1'b0) begin
                failures++; $display("FAIL dir%0d_pulse_clear done=%b dbz=%b exp=0/0", i, dn_after, dbz_after);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [31:0] rhi, rlo, ehi, elo, xa, xb;
        logic rdbz, edbz, dn_after, dbz_after;
        logic [1:0] o;
        for (int i = 0; i < 40; i++) begin
            o  = 2'($urandom_range(0, 3));
            xa = $urandom;
            xb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) xb = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 5) == 0) xa = 32'h8000_0000;
            ref_model(o, xa, xb, ehi, elo, edbz);
            run_op(o, xa, xb, lat, bcnt, rhi, rlo, rdbz, dn_after, dbz_after);
            checks++; if (lat != 34) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=34", i, lat); end
            checks++; if (rhi !== ehi || rlo !== elo || rdbz !== edbz) begin
                failures++;
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=%b",
                         i, o, xa, xb, rhi, rlo, rdbz, ehi, elo, edbz);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++; if (hi !== ehi || lo !== elo) begin
                failures++; $display("FAIL rnd%0d_hold got hi=%h lo=%h exp hi=%h lo=%h", i, hi, lo, ehi, elo);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int first = 0;
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (done) begin
                dones++;
                if (first == 0) first = c;
            end
            if (c == 5) begin start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (dones != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        checks++; if (first != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", first); end
        checks++; if (hi !== 32'h0 || lo !== 32'h2A) begin
            failures++; $display("FAIL ignore_result got hi=%h lo=%h exp hi=0 lo=2a", hi, lo);
        end
    endtask

    task automatic test_mt();
        int lat, bcnt;
        logic [31:0] rhi, rlo;
        logic rdbz, dn_after, dbz_after;
        logic [31:0] prev_hi;
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h1111_2222;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h3333_4444;
        checks++; if (hi !== 32'h1111_2222 || done !== 1'b0) begin
            failures++; $display("FAIL mthi got hi=%h done=%b exp hi=11112222 done=0", hi, done);
        end
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h3333_4444 || hi !== 32'h1111_2222 || done !== 1'b0) begin
            failures++; $display("FAIL mtlo got hi=%h lo=%h done=%b exp hi=11112222 lo=33334444 done=0", hi, lo, done);
        end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h5A5A_A5A5 || lo !== 32'h5A5A_A5A5) begin
            failures++; $display("FAIL mt_both got hi=%h lo=%h exp 5a5aa5a5/5a5aa5a5", hi, lo);
        end
        // start and MTHI in the same cycle: start wins, HI keeps its value until the result lands
        prev_hi = hi;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4; hi_we = 1'b1; wdata = 32'hDEAD_0000;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        checks++; if (hi !== prev_hi) begin failures++; $display("FAIL mt_start_wins got hi=%h exp=%h", hi, prev_hi); end
        @(posedge clk); #1;
        lo_we = 1'b1; wdata = 32'hBEEF_0000;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h5A5A_A5A5) begin failures++; $display("FAIL mt_ignored_busy got lo=%h exp=5a5aa5a5", lo); end
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'hC) begin
            failures++; $display("FAIL mt_after_op got done=%b hi=%h lo=%h exp 1/0/c", done, hi, lo);
        end
        @(posedge clk); #1;
        run_op(2'b10, 32'd100, 32'd7, lat, bcnt, rhi, rlo, rdbz, dn_after, dbz_after);
        checks++; if (rhi !== 32'd2 || rlo !== 32'd14) begin
            failures++; $display("FAIL mt_followup_divu got hi=%h lo=%h exp 2/e", rhi, rlo);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_ctrl got busy=%b done=%b exp 0/0", busy, done);
        end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++; $display("FAIL abort_regs got hi=%h lo=%h exp 0/0", hi, lo);
        end
        for (int c = 0; c < 40; c++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", dones); end
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h1234 || done !== 1'b0 || hi !== 32'h0) begin
            failures++; $display("FAIL abort_mtlo got lo=%h done=%b hi=%h exp 1234/0/0", lo, done, hi);
        end
    endtask

    initial begin
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rst_n = 1'b0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_mt();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
